// File: rtl/uacc_pkg.sv
// Shared types and defaults for the uacc accumulator stage.
package uacc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int GUARD_DEF   = 8;
  localparam int MAX_LEN_DEF = 256;

endpackage

// File: rtl/uacc_if.sv
// fixedp carries the fixed-point format plus clock/reset; uacc_if carries the
// product stream in and the normalized result out, both valid/ready.
interface fixedp #(
  parameter int WIDTH = 16,
  parameter int SCALE = 8
);
  logic clk;
  logic reset_l;

  modport master (output clk, reset_l);
  modport slave  (input  clk, reset_l);
endinterface

interface uacc_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   in_prod;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_f;
  logic                 out_sat;
  logic                 out_len_err;
  logic [CNT_W-1:0]     out_count;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_f, out_sat, out_len_err, out_count
  );
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_f, out_sat, out_len_err, out_count
  );
endinterface

// File: rtl/unorm.sv
// Rescales an unsigned fixed-point value to a narrower format (floor), clamping
// to all ones on overflow. Purely combinational, no handshake.
module unorm #(
  parameter int A_WIDTH = 32,
  parameter int A_SCALE = 16,
  parameter int F_WIDTH = 16,
  parameter int F_SCALE = 8
) (
  input  logic [A_WIDTH-1:0] a_i,
  output logic [F_WIDTH-1:0] f_o
);
  localparam int SH = A_SCALE - F_SCALE;

  logic [A_WIDTH-1:0] shifted;
  assign shifted = a_i >> SH;

  generate
    if (A_WIDTH > F_WIDTH) begin : g_clamp
      assign f_o = (|shifted[A_WIDTH-1:F_WIDTH]) ? '1 : shifted[F_WIDTH-1:0];
    end else begin : g_fit
      assign f_o = F_WIDTH'(shifted);
    end
  endgenerate
endmodule

// File: rtl/uacc.sv
// Sums raw product vectors into a guarded accumulator; result valid the cycle after the last beat.
// in_ready drops while a result waits for out_ready, so one idle cycle separates vectors.
module uacc
  import uacc_pkg::*;
#(
  parameter int GUARD   = GUARD_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  fixedp.slave  g,
  uacc_if.slave hs
);
  localparam int WIDTH = g.WIDTH;
  localparam int SCALE = g.SCALE;
  localparam int P_W   = 2 * WIDTH;
  localparam int ACC_W = P_W + GUARD;
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  state_t           state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             acc_sat_q, acc_sat_d;
  logic             len_err_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             beat;
  logic             at_limit;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum;

  assign beat     = hs.in_valid && in_ready_q;
  assign prod_ext = {{(ACC_W + 1 - P_W){1'b0}}, hs.in_prod};
  assign sum      = {1'b0, acc_q} + prod_ext;

  // A carry out of the guarded add pins the accumulator at all ones for the rest of the vector.
  always_comb begin
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    count_d   = count_q + CNT_W'(1);
    if (state_q == IDLE) begin
      acc_d   = prod_ext[ACC_W-1:0];
      count_d = CNT_W'(1);
    end else if (sum[ACC_W]) begin
      acc_d     = '1;
      acc_sat_d = 1'b1;
    end else begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  assign at_limit = (count_d == CNT_W'(MAX_LEN));

  always_ff @(posedge g.clk or negedge g.reset_l) begin
    if (!g.reset_l) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      acc_sat_q   <= 1'b0;
      len_err_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          in_ready_q <= 1'b1;
          if (beat) begin
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
            count_q   <= count_d;
            if (hs.in_last || at_limit) begin
              state_q     <= DONE;
              len_err_q   <= !hs.in_last;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACC;
            end
          end
        end
        DONE: begin
          if (hs.out_ready) begin
            state_q     <= IDLE;
            acc_sat_q   <= 1'b0;
            len_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign hs.in_ready    = in_ready_q;
  assign hs.out_valid   = out_valid_q;
  assign hs.out_count   = count_q;
  assign hs.out_len_err = len_err_q;
  assign hs.out_sat     = acc_sat_q | (|acc_q[ACC_W-1:WIDTH+SCALE]);

  unorm #(
    .A_WIDTH (ACC_W),
    .A_SCALE (2 * SCALE),
    .F_WIDTH (WIDTH),
    .F_SCALE (SCALE)
  ) u_norm (
    .a_i (acc_q),
    .f_o (hs.out_f)
  );
endmodule

// File: tb/tb_uacc.sv
// Directed plus random stimulus for uacc (WIDTH=16, SCALE=8, MAX_LEN=4), GUARD=8 and GUARD=0 side by side.
module tb_uacc;
  localparam int MAXL = 4;

  fixedp  #(.WIDTH(16), .SCALE(8))  g ();
  uacc_if #(.WIDTH(16), .CNT_W(3))  hs ();
  uacc_if #(.WIDTH(16), .CNT_W(3))  hs0 ();

  uacc #(.GUARD(8), .MAX_LEN(MAXL)) u_dut    (.g(g), .hs(hs));
  uacc #(.GUARD(0), .MAX_LEN(MAXL)) u_dut_g0 (.g(g), .hs(hs0));

  assign hs0.in_valid  = hs.in_valid;
  assign hs0.in_prod   = hs.in_prod;
  assign hs0.in_last   = hs.in_last;
  assign hs0.out_ready = hs.out_ready;

  initial begin
    g.clk = 1'b0;
    forever #5 g.clk = ~g.clk;
  end

  typedef struct {
    logic [15:0] f;
    logic        s;
    logic [15:0] f0;
    logic        s0;
    logic        le;
    logic [2:0]  cnt;
  } exp_t;

  exp_t            exp_q[$];
  longint unsigned m_acc[2];
  bit              m_sat[2];
  int              m_cnt;
  bit              m_act;
  int              n_cmp;
  int              n_err;
  int              last_wait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] norm(input longint unsigned a);
    longint unsigned q;
    q = a >> 8;
    return (q > 64'd65535) ? 16'hFFFF : q[15:0];
  endfunction

  // Reference: a vector is a running sum of products, capped at the accumulator's range.
  task automatic model_beat(input logic [31:0] p, input logic l);
    exp_t            e;
    longint unsigned lim;
    if (!m_act) begin
      m_act = 1;
      m_cnt = 0;
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0;
        m_sat[k] = 0;
      end
    end
    m_cnt++;
    for (int k = 0; k < 2; k++) begin
      lim = (64'd1 << ((k == 0) ? 40 : 32)) - 1;
      m_acc[k] += longint'(p);
      if (m_acc[k] > lim) begin
        m_acc[k] = lim;
        m_sat[k] = 1;
      end
    end
    if (l || m_cnt == MAXL) begin
      e.f   = norm(m_acc[0]);
      e.s   = m_sat[0] || (m_acc[0] >= (64'd1 << 24));
      e.f0  = norm(m_acc[1]);
      e.s0  = m_sat[1] || (m_acc[1] >= (64'd1 << 24));
      e.le  = !l;
      e.cnt = 3'(m_cnt);
      exp_q.push_back(e);
      m_act = 0;
    end
  endtask

  // Called at a falling edge with a result pending; holds out_ready low for 'hold' cycles first.
  task automatic take(input int hold);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("spurious_result", 1, 0);
      hs.out_ready = 1'b1;
      @(posedge g.clk);
      @(negedge g.clk);
      hs.out_ready = 1'b0;
      return;
    end
    e = exp_q[0];
    for (int i = 0; i <= hold; i++) begin
      hs.out_ready = (i == hold);
      chk("out_valid",   hs.out_valid,   1);
      chk("in_ready_lo", hs.in_ready,    0);
      chk("out_f",       hs.out_f,       e.f);
      chk("out_sat",     hs.out_sat,     e.s);
      chk("out_len_err", hs.out_len_err, e.le);
      chk("out_count",   hs.out_count,   e.cnt);
      chk("g0_out_f",    hs0.out_f,      e.f0);
      chk("g0_out_sat",  hs0.out_sat,    e.s0);
      chk("g0_valid",    hs0.out_valid,  1);
      @(posedge g.clk);
      @(negedge g.clk);
    end
    hs.out_ready = 1'b0;
    void'(exp_q.pop_front());
    chk("valid_drop",   hs.out_valid, 0);
    chk("ready_return", hs.in_ready,  1);
  endtask

  // Presents one beat at a falling edge and waits for acceptance, draining results in the way.
  task automatic send(input logic [31:0] p, input logic l);
    int budget;
    bit ok;
    budget      = 60;
    ok          = 0;
    last_wait   = 0;
    hs.in_valid = 1'b1;
    hs.in_prod  = p;
    hs.in_last  = l;
    while (!ok && budget > 0) begin
      budget--;
      if (hs.in_ready) begin
        chk("g0_in_ready", hs0.in_ready, 1);
        @(posedge g.clk);
        model_beat(p, l);
        ok = 1;
      end else if (hs.out_valid) begin
        take($urandom_range(0, 2));
        last_wait++;
        continue;
      end else begin
        @(posedge g.clk);
        last_wait++;
      end
      @(negedge g.clk);
    end
    hs.in_valid = 1'b0;
    hs.in_last  = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
    chk("valid_latency", hs.out_valid, (exp_q.size() > 0) ? 1 : 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  hs.in_ready,    0);
    chk({tag, "_out_valid"}, hs.out_valid,   0);
    chk({tag, "_out_f"},     hs.out_f,       0);
    chk({tag, "_out_sat"},   hs.out_sat,     0);
    chk({tag, "_len_err"},   hs.out_len_err, 0);
    chk({tag, "_count"},     hs.out_count,   0);
    chk({tag, "_g0_valid"},  hs0.out_valid,  0);
    chk({tag, "_g0_f"},      hs0.out_f,      0);
  endtask

  initial begin
    logic [31:0] p;
    n_cmp        = 0;
    n_err        = 0;
    m_act        = 0;
    g.reset_l    = 1'b0;
    hs.in_valid  = 1'b0;
    hs.in_prod   = '0;
    hs.in_last   = 1'b0;
    hs.out_ready = 1'b0;

    repeat (2) @(negedge g.clk);
    chk_all_zero("reset");
    g.reset_l = 1'b1;
    @(negedge g.clk);
    chk("post_reset_ready", hs.in_ready, 1);

    // Three-beat sum
    send(32'h0001_0000, 0);
    send(32'h0001_0000, 0);
    send(32'h0001_0000, 1);
    chk("sum_f", hs.out_f, 16'h0300);
    chk("sum_count", hs.out_count, 3);
    chk("sum_sat", hs.out_sat, 0);
    take(0);

    // Single beat
    send(32'h0002_8000, 1);
    chk("single_f", hs.out_f, 16'h0280);
    chk("single_count", hs.out_count, 1);
    take(0);

    // Saturation, both guard widths
    send(32'hFFFF_FFFF, 0);
    send(32'hFFFF_FFFF, 1);
    chk("sat_f", hs.out_f, 16'hFFFF);
    chk("sat_flag", hs.out_sat, 1);
    chk("g0_sat_f", hs0.out_f, 16'hFFFF);
    chk("g0_sat_flag", hs0.out_sat, 1);
    take(0);

    // Length limit then a fresh vector
    repeat (4) send(32'h0000_0100, 0);
    chk("len_err", hs.out_len_err, 1);
    chk("len_count", hs.out_count, 4);
    chk("len_f", hs.out_f, 16'h0004);
    take(0);
    send(32'h0000_0100, 1);
    chk("after_len_f", hs.out_f, 16'h0001);
    chk("after_len_count", hs.out_count, 1);
    chk("after_len_err", hs.out_len_err, 0);
    take(0);

    // Backpressure: five stalled cycles, then the next vector goes straight in
    send(32'h0003_0000, 1);
    take(5);
    send(32'h0001_0000, 1);
    chk("next_vec_immediate", last_wait, 0);
    take(0);

    // Asynchronous reset mid-vector
    send(32'h0005_0000, 0);
    send(32'h0007_0000, 0);
    #2;
    g.reset_l = 1'b0;
    #1;
    chk_all_zero("async_rst");
    m_act = 0;
    exp_q.delete();
    @(negedge g.clk);
    g.reset_l = 1'b1;
    @(negedge g.clk);
    send(32'h0001_0000, 1);
    chk("post_rst_f", hs.out_f, 16'h0100);
    chk("post_rst_count", hs.out_count, 1);
    take(0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge g.clk);
      p = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 32'h0003_FFFF);
      send(p, ($urandom_range(0, 3) == 0));
    end
    if (m_act) send($urandom_range(0, 32'h0003_FFFF), 1);
    if (exp_q.size() > 0) take($urandom_range(0, 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uacc.md
# uacc

Unsigned fixed-point accumulator stage placed directly downstream of `umul_raw`. It consumes a stream of full-precision raw products (2·WIDTH bits, scale 2·SCALE) with a valid/ready handshake and sums each vector delimited by `in_last` in a guarded accumulator. It emits one normalized WIDTH/SCALE result per vector, with saturation and length-error flags. Together with `umul_raw` it forms the unsigned dot-product / MAC path.

## Interface
Parameters:
- `GUARD`, 8: extra accumulator MSBs above 2·g.WIDTH; ACC_W = 2·g.WIDTH + GUARD.
- `MAX_LEN`, 256: maximum beats per vector; CNT_W = $clog2(MAX_LEN+1).

Ports:
- `g.clk`  in  1  clock, carried in the `fixedp g` bundle.
- `g.reset_l`  in  1  reset, carried in `g`. One clock; reset is asynchronous, active-low.
- `g`  interface  -  fixed-point parameters (WIDTH, SCALE) and common ports.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_prod`  in  2·WIDTH  raw unsigned product, scale 2·SCALE.
- `in_last`  in  1  final beat of the vector.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_f`  out  WIDTH  normalized sum, scale SCALE.
- `out_sat`  out  1  result clamped, or accumulator saturated.
- `out_len_err`  out  1  vector force-terminated at MAX_LEN without `in_last`.
- `out_count`  out  CNT_W  number of beats summed.

## Operation
- States are IDLE, ACC and DONE. Reset enters IDLE, clears acc, count and the sticky flags, and drives `out_valid`=0 and `in_ready`=0 during reset.
- `in_ready` = 1 in IDLE and ACC, and 0 in DONE.
- IDLE, on an accepted beat:
  - acc ← zero-extended `in_prod`; count ← 1.
  - Go to ACC, or to DONE if `in_last`.
- ACC, on an accepted beat:
  - acc ← acc + `in_prod`; count ← count + 1.
  - Go to DONE if `in_last`, or if count was MAX_LEN−1. The second case also sets `len_err`.
- Saturation: if the ACC_W-bit add carries out, acc ← all ones and sticky `acc_sat` is set. Further adds keep acc at all ones.
- DONE:
  - `out_valid`=1. Move to IDLE on `out_ready`.
  - acc, count and the flags are held until then.
  - Leaving DONE clears `acc_sat` and `len_err`.
- `out_f` = floor(acc / 2^SCALE), clamped to 2^WIDTH−1.
- `out_sat` = `acc_sat` OR (acc ≥ 2^(WIDTH+SCALE)).
- No-valid cycles in ACC are bubbles and leave state unchanged.

## Timing
- Throughput is one beat per clock within a vector.
- Latency: last beat accepted at edge t gives `out_valid`=1 after edge t, so it is visible in cycle t+1.
- Minimum gap between vectors is one cycle: DONE accepts no input, and the first beat of the next vector can be accepted in the cycle after the handshake.
- `out_f`, `out_sat`, `out_len_err` and `out_count` are stable while `out_valid && !out_ready`.
- Asynchronous reset mid-vector or in DONE discards the partial sum and any pending result. The first accepted beat after reset release starts a new vector.
- All outputs are combinational from registered state only; there is no input-to-output combinational path.

## Structure
- `uacc_pkg` holds the state enum (IDLE, ACC, DONE) and the default GUARD and MAX_LEN values.
- Normalization uses an instance of the existing `unorm` with A_WIDTH=ACC_W, A_SCALE=2·SCALE, F_WIDTH=WIDTH, F_SCALE=SCALE. The clamp check for `out_sat` is computed locally.
- Accumulator, counter and FSM live in this module; no other sub-module is needed.

## Test plan
(WIDTH=16, SCALE=8, GUARD=8, MAX_LEN=4 unless stated.)
- Sum: beats 0x00010000 ×3, `in_last` on the 3rd → `out_f`=0x0300, `out_count`=3, `out_sat`=0, `out_valid` high exactly 1 cycle after the 3rd beat.
- Single beat: 0x00028000 with `in_last` → `out_f`=0x0280, `out_count`=1.
- Saturation: 0xFFFFFFFF, then 0xFFFFFFFF with `in_last` → `out_f`=0xFFFF, `out_sat`=1. Same test with GUARD=0 sets `acc_sat` (acc all ones).
- Length error: 4 beats of 0x00000100 with no `in_last` → result after the 4th beat with `out_len_err`=1, `out_count`=4, `out_f`=0x0004. The 5th beat starts a new vector.
- Backpressure: hold `out_ready`=0 for 5 cycles → `in_ready`=0 throughout and outputs unchanged. Releasing it gives a one-cycle handshake and the next vector is accepted the following cycle.
- Reset: assert `g.reset_l`=0 asynchronously after 2 beats → all outputs 0 immediately. A new 1-beat vector of 0x00010000 then yields 0x0100, with no contribution from the discarded beats.
